// File: rtl/fifo_2w_wr_arb_if.sv
`default_nettype none
// ============================================================================
// Module      : fifo_2w_wr_arb_if
// Description : Bundle of the two producer lanes, the downstream occupancy
//               input and the two FIFO write ports of fifo_2w_wr_arb.
//               master = producer/FIFO side, slave = arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_2w_wr_arb_if #(
    parameter int FIFO_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    logic                  in_val_0;
    logic [FIFO_WIDTH-1:0] in_data_0;
    logic                  in_rdy_0;
    logic                  in_val_1;
    logic [FIFO_WIDTH-1:0] in_data_1;
    logic                  in_rdy_1;
    logic [CNT_WIDTH-1:0]  size;
    logic                  w_val_0;
    logic [FIFO_WIDTH-1:0] w_data_0;
    logic                  w_val_1;
    logic [FIFO_WIDTH-1:0] w_data_1;

    modport master (
        output in_val_0, in_data_0, in_val_1, in_data_1, size,
        input  in_rdy_0, in_rdy_1, w_val_0, w_data_0, w_val_1, w_data_1
    );

    modport slave (
        input  in_val_0, in_data_0, in_val_1, in_data_1, size,
        output in_rdy_0, in_rdy_1, w_val_0, w_data_0, w_val_1, w_data_1
    );
endinterface
`default_nettype wire

// File: rtl/fifo_2w_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : fifo_2w_wr_arb
// Description : Merges two valid/ready producer lanes into the two write
//               ports of the dual-write FIFO. Each lane has a 2-entry holding
//               buffer; writes are issued only when the FIFO's registered
//               occupancy guarantees acceptance. Round-robin between lanes.
// Options     : `define FIFO_2W_WR_ARB_STATS_EN adds stat_cnt_0/1 (entries
//               written per lane) and stat_stall (pending but no capacity).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_2w_wr_arb #(
    parameter int FIFO_WIDTH = 32,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fifo_2w_wr_arb_if.slave    arb_if
`ifdef FIFO_2W_WR_ARB_STATS_EN
    ,
    output logic [31:0]        stat_cnt_0,
    output logic [31:0]        stat_cnt_1,
    output logic [31:0]        stat_stall
`endif
);

    localparam logic [CNT_WIDTH-1:0] C_SIZE_ONE_FREE = CNT_WIDTH'(FIFO_DEPTH - 2);
    localparam logic [FIFO_WIDTH-1:0] C_IDLE_DATA    = '1;

    // Per-lane holding buffer state
    logic [FIFO_WIDTH-1:0] mem_q [2][2];
    logic [1:0]            cnt_q [2];
    logic [1:0]            rd_q;
    logic [1:0]            wr_q;
    logic                  rr_q;
    logic                  rr_d;

    logic [1:0]            pend;
    logic [1:0]            push;
    logic [1:0]            pop;
    logic [1:0]            cap;
    logic [FIFO_WIDTH-1:0] head [2];
    logic [FIFO_WIDTH-1:0] in_data [2];

    assign in_data[0] = arb_if.in_data_0;
    assign in_data[1] = arb_if.in_data_1;

    // Ready depends on registered count only, keeping size/w_val off this path
    assign arb_if.in_rdy_0 = (cnt_q[0] < 2'd2);
    assign arb_if.in_rdy_1 = (cnt_q[1] < 2'd2);
    assign push[0] = arb_if.in_val_0 & arb_if.in_rdy_0;
    assign push[1] = arb_if.in_val_1 & arb_if.in_rdy_1;

    assign pend[0] = (cnt_q[0] != 2'd0);
    assign pend[1] = (cnt_q[1] != 2'd0);
    assign head[0] = mem_q[0][rd_q[0]];
    assign head[1] = mem_q[1][rd_q[1]];

    // Guaranteed free slots from the FIFO's registered occupancy; a read in
    // the same cycle is deliberately not credited
    always_comb begin
        if (arb_if.size < C_SIZE_ONE_FREE)
            cap = 2'd2;
        else if (arb_if.size == C_SIZE_ONE_FREE)
            cap = 2'd1;
        else
            cap = 2'd0;
    end

    // Grant: rr_q names the first lane, which takes port 0 under contention
    always_comb begin
        arb_if.w_val_0  = 1'b0;
        arb_if.w_data_0 = C_IDLE_DATA;
        arb_if.w_val_1  = 1'b0;
        arb_if.w_data_1 = C_IDLE_DATA;
        pop             = 2'b00;
        rr_d            = rr_q;
        if (cap != 2'd0) begin
            if (pend == 2'b11) begin
                arb_if.w_val_0  = 1'b1;
                arb_if.w_data_0 = head[rr_q];
                pop[rr_q]       = 1'b1;
                rr_d            = ~rr_q;
                if (cap == 2'd2) begin
                    arb_if.w_val_1  = 1'b1;
                    arb_if.w_data_1 = head[~rr_q];
                    pop[~rr_q]      = 1'b1;
                end
            end else if (pend[0]) begin
                arb_if.w_val_0  = 1'b1;
                arb_if.w_data_0 = head[0];
                pop[0]          = 1'b1;
            end else if (pend[1]) begin
                arb_if.w_val_0  = 1'b1;
                arb_if.w_data_0 = head[1];
                pop[1]          = 1'b1;
            end
        end
    end

    // Lane buffers and round-robin pointer; reset discards buffered entries
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 2; l++) begin
                cnt_q[l] <= 2'd0;
                for (int e = 0; e < 2; e++)
                    mem_q[l][e] <= '0;
            end
            rd_q <= 2'b00;
            wr_q <= 2'b00;
            rr_q <= 1'b0;
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (push[l]) begin
                    mem_q[l][wr_q[l]] <= in_data[l];
                    wr_q[l]           <= ~wr_q[l];
                end
                if (pop[l])
                    rd_q[l] <= ~rd_q[l];
                cnt_q[l] <= cnt_q[l] + {1'b0, push[l]} - {1'b0, pop[l]};
            end
            rr_q <= rr_d;
        end
    end

`ifdef FIFO_2W_WR_ARB_STATS_EN
    logic [31:0] stat_cnt_0_q;
    logic [31:0] stat_cnt_1_q;
    logic [31:0] stat_stall_q;

    // Free-running statistics, wrapping modulo 2^32
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_cnt_0_q <= '0;
            stat_cnt_1_q <= '0;
            stat_stall_q <= '0;
        end else begin
            stat_cnt_0_q <= stat_cnt_0_q + {31'd0, pop[0]};
            stat_cnt_1_q <= stat_cnt_1_q + {31'd0, pop[1]};
            if ((pend != 2'b00) && (cap == 2'd0))
                stat_stall_q <= stat_stall_q + 32'd1;
        end
    end

    assign stat_cnt_0 = stat_cnt_0_q;
    assign stat_cnt_1 = stat_cnt_1_q;
    assign stat_stall = stat_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fifo_2w_wr_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_2w_wr_arb
// Description : Directed self-checking bench for fifo_2w_wr_arb
//               (FIFO_WIDTH=32, FIFO_DEPTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_2w_wr_arb;

    localparam int FIFO_WIDTH = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_WIDTH  = 4;
    localparam logic [31:0] C_ONES = 32'hFFFF_FFFF;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fifo_2w_wr_arb_if #(.FIFO_WIDTH(FIFO_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

`ifdef FIFO_2W_WR_ARB_STATS_EN
    logic [31:0] stat_cnt_0;
    logic [31:0] stat_cnt_1;
    logic [31:0] stat_stall;
`endif

    fifo_2w_wr_arb #(
        .FIFO_WIDTH(FIFO_WIDTH),
        .FIFO_DEPTH(FIFO_DEPTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .arb_if    (bus.slave)
`ifdef FIFO_2W_WR_ARB_STATS_EN
        ,
        .stat_cnt_0(stat_cnt_0),
        .stat_cnt_1(stat_cnt_1),
        .stat_stall(stat_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Step past the active edge so inputs change and outputs are sampled away from it
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic settle;
        #1;
    endtask

    logic [31:0] base [2];
    int          popc [2];
    int          gcnt [2];
    int          npush[2];
    logic        exp_rr;
    logic        acc0, acc1;

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n         = 1'b0;
        bus.in_val_0  = 1'b0;
        bus.in_data_0 = '0;
        bus.in_val_1  = 1'b0;
        bus.in_data_1 = '0;
        bus.size      = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        settle();
        check("rst_rdy0",  {31'd0, bus.in_rdy_0}, 32'd1);
        check("rst_rdy1",  {31'd0, bus.in_rdy_1}, 32'd1);
        check("rst_wval0", {31'd0, bus.w_val_0},  32'd0);
        check("rst_wval1", {31'd0, bus.w_val_1},  32'd0);
        check("rst_wdat0", bus.w_data_0, C_ONES);
        check("rst_wdat1", bus.w_data_1, C_ONES);

        // Single lane: 1-cycle latency, no bypass
        bus.in_val_0  = 1'b1;
        bus.in_data_0 = 32'hA1;
        settle();
        check("single_nobypass", {31'd0, bus.w_val_0}, 32'd0);
        tick();
        bus.in_val_0 = 1'b0;
        settle();
        check("single_wval0", {31'd0, bus.w_val_0}, 32'd1);
        check("single_wdat0", bus.w_data_0, 32'hA1);
        check("single_wval1", {31'd0, bus.w_val_1}, 32'd0);
        check("single_wdat1", bus.w_data_1, C_ONES);
        tick();
        settle();
        check("single_empty", {31'd0, bus.w_val_0}, 32'd0);
        check("single_idle_dat", bus.w_data_0, C_ONES);

        // Dual write with rr=0: load both lanes while cap=0, then open
        bus.size      = 4'd7;
        bus.in_val_0  = 1'b1;
        bus.in_data_0 = 32'h10;
        bus.in_val_1  = 1'b1;
        bus.in_data_1 = 32'h20;
        tick();
        bus.in_val_0 = 1'b0;
        bus.in_val_1 = 1'b0;
        settle();
        check("dual_hold_cap0", {31'd0, bus.w_val_0}, 32'd0);
        bus.size = 4'd0;
        settle();
        check("dual_wval0", {31'd0, bus.w_val_0}, 32'd1);
        check("dual_wdat0", bus.w_data_0, 32'h10);
        check("dual_wval1", {31'd0, bus.w_val_1}, 32'd1);
        check("dual_wdat1", bus.w_data_1, 32'h20);
        tick();
        settle();
        check("dual_empty", {31'd0, bus.w_val_0}, 32'd0);

        // Capacity 1 with rr=1: lane 1 goes first, then rr returns to 0
        bus.size      = 4'd7;
        bus.in_val_0  = 1'b1;
        bus.in_data_0 = 32'h30;
        bus.in_val_1  = 1'b1;
        bus.in_data_1 = 32'h40;
        tick();
        bus.in_val_0 = 1'b0;
        bus.in_val_1 = 1'b0;
        bus.size     = 4'd6;
        settle();
        check("cap1_rr1_wval0", {31'd0, bus.w_val_0}, 32'd1);
        check("cap1_rr1_wdat0", bus.w_data_0, 32'h40);
        check("cap1_rr1_wval1", {31'd0, bus.w_val_1}, 32'd0);
        tick();
        bus.size      = 4'd7;
        bus.in_val_1  = 1'b1;
        bus.in_data_1 = 32'h50;
        settle();
        check("cap0_nowrite", {31'd0, bus.w_val_0}, 32'd0);
        tick();
        bus.in_val_1 = 1'b0;
        bus.size     = 4'd6;
        settle();
        // Both pending, rr=0, cap=1: lane 0 only
        check("cap1_wval0", {31'd0, bus.w_val_0}, 32'd1);
        check("cap1_wdat0", bus.w_data_0, 32'h30);
        check("cap1_wval1", {31'd0, bus.w_val_1}, 32'd0);
        tick();
        bus.size = 4'd7;
        settle();
        check("cap1_next_size7", {31'd0, bus.w_val_0}, 32'd0);
        bus.size = 4'd0;
        settle();
        check("cap1_drain_dat", bus.w_data_0, 32'h50);
        check("cap1_drain_val1", {31'd0, bus.w_val_1}, 32'd0);
        tick();

        // Backpressure on lane 1 with size held at 7
        bus.size      = 4'd7;
        bus.in_val_1  = 1'b1;
        bus.in_data_1 = 32'h61;
        tick();
        bus.in_data_1 = 32'h62;
        settle();
        check("bp_rdy_after1", {31'd0, bus.in_rdy_1}, 32'd1);
        tick();
        bus.in_data_1 = 32'h63;
        settle();
        check("bp_rdy_full", {31'd0, bus.in_rdy_1}, 32'd0);
        check("bp_no_wval", {31'd0, bus.w_val_0}, 32'd0);
        tick();
        bus.in_val_1 = 1'b0;
        bus.size     = 4'd0;
        settle();
        check("bp_out1", bus.w_data_0, 32'h61);
        check("bp_out1_val1", {31'd0, bus.w_val_1}, 32'd0);
        tick();
        settle();
        check("bp_out2", bus.w_data_0, 32'h62);
        tick();
        settle();
        check("bp_drained", {31'd0, bus.w_val_0}, 32'd0);

        // Fairness: both lanes streaming, size 6; rr is 1 at this point
        base[0] = 32'h100;
        base[1] = 32'h200;
        popc[0] = 0; popc[1] = 0;
        gcnt[0] = 0; gcnt[1] = 0;
        npush[0] = 0; npush[1] = 0;
        exp_rr = 1'b1;
        bus.size      = 4'd6;
        bus.in_val_0  = 1'b1;
        bus.in_val_1  = 1'b1;
        bus.in_data_0 = base[0];
        bus.in_data_1 = base[1];
        tick();
        npush[0] = 1; npush[1] = 1;
        bus.in_data_0 = base[0] + 32'(npush[0]);
        bus.in_data_1 = base[1] + 32'(npush[1]);
        for (int i = 0; i < 8; i++) begin
            settle();
            check("fair_wval0", {31'd0, bus.w_val_0}, 32'd1);
            check("fair_wval1", {31'd0, bus.w_val_1}, 32'd0);
            check("fair_wdat0", bus.w_data_0, base[exp_rr] + 32'(popc[exp_rr]));
            popc[exp_rr]++;
            gcnt[exp_rr]++;
            exp_rr = ~exp_rr;
            acc0 = bus.in_rdy_0;
            acc1 = bus.in_rdy_1;
            tick();
            if (acc0) npush[0]++;
            if (acc1) npush[1]++;
            bus.in_data_0 = base[0] + 32'(npush[0]);
            bus.in_data_1 = base[1] + 32'(npush[1]);
        end
        check("fair_grants0", 32'(gcnt[0]), 32'd4);
        check("fair_grants1", 32'(gcnt[1]), 32'd4);

        // Fill both buffers, then reset mid-stream
        bus.size = 4'd7;
        tick();
        tick();
        tick();
        settle();
        check("full_rdy0", {31'd0, bus.in_rdy_0}, 32'd0);
        check("full_rdy1", {31'd0, bus.in_rdy_1}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n        = 1'b1;
        bus.in_val_0 = 1'b0;
        bus.in_val_1 = 1'b0;
        bus.size     = 4'd0;
        settle();
        check("mrst_wval0", {31'd0, bus.w_val_0}, 32'd0);
        check("mrst_wval1", {31'd0, bus.w_val_1}, 32'd0);
        check("mrst_rdy0",  {31'd0, bus.in_rdy_0}, 32'd1);
        check("mrst_rdy1",  {31'd0, bus.in_rdy_1}, 32'd1);
`ifdef FIFO_2W_WR_ARB_STATS_EN
        check("mrst_stat0", stat_cnt_0, 32'd0);
        check("mrst_stat1", stat_cnt_1, 32'd0);
        check("mrst_stall", stat_stall, 32'd0);
`endif
        tick();
        settle();
        check("mrst_still_empty", {31'd0, bus.w_val_0}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/fifo_2w_wr_arb.md
Name: fifo_2w_wr_arb

Overview:
- Upstream feeder for the dual-write FIFO: merges two independent producer lanes (valid/ready) into that FIFO's two write ports.
- Issues only writes the FIFO is guaranteed to accept, based on the FIFO's registered occupancy. Never relies on the FIFO's silent-drop behaviour.
- Each lane has a 2-entry holding buffer. Round-robin priority decides which lane goes first, and which lane wins when only one slot is free.

Parameters:
- FIFO_WIDTH, 32, entry width in bits; matches the downstream FIFO.
- FIFO_DEPTH, 8, downstream FIFO depth; legal values are at least 3.
- CNT_WIDTH, clogb2(FIFO_DEPTH)+1, width of the downstream size bus.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_val_0  in  1  lane 0 producer valid
- in_data_0  in  FIFO_WIDTH  lane 0 producer data
- in_rdy_0  out  1  lane 0 holding buffer can take an entry
- in_val_1  in  1  lane 1 producer valid
- in_data_1  in  FIFO_WIDTH  lane 1 producer data
- in_rdy_1  out  1  lane 1 holding buffer can take an entry
- size  in  CNT_WIDTH  downstream FIFO occupancy (its registered count)
- w_val_0  out  1  FIFO write port 0 valid
- w_data_0  out  FIFO_WIDTH  FIFO write port 0 data (enqueued first)
- w_val_1  out  1  FIFO write port 1 valid
- w_data_1  out  FIFO_WIDTH  FIFO write port 1 data (enqueued second)

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is synchronous, active-low, sampled on posedge clk.
- Reset state:
  - Lane buffers empty (count 0; rd/wr pointers 0).
  - rr_ptr = 0.
  - in_rdy_0/1 = 1 from the first cycle after reset release.
  - w_val_0/1 = 0 and w_data_0/1 = all-ones while buffers are empty.
- Lane buffer:
  - 2-entry circular FIFO per lane with a registered count.
  - in_rdy_n = (count_n < 2), derived from registered count only. There is no combinational path from w_val or size to in_rdy.
  - A push occurs when in_val_n & in_rdy_n.
  - Push and pop may occur in the same cycle.
  - With count 2 and a pop, in_rdy stays 0 that cycle.
  - No bypass: an accepted entry can reach w_val no earlier than the next cycle (1-cycle minimum latency).
  - Per-lane order is preserved.
- Capacity, computed combinationally from size:
  - cap = 2 when size < FIFO_DEPTH-2.
  - cap = 1 when size == FIFO_DEPTH-2.
  - cap = 0 otherwise.
  - Comparisons are unsigned at CNT_WIDTH.
  - A FIFO read in the same cycle is ignored, which is conservative and matches the FIFO's own acceptance rule.
- Grant (combinational). Let p0/p1 be "lane buffer non-empty" and F = lane rr_ptr, S = the other lane:
  - cap = 0: no grants.
  - Exactly one lane pending and cap ≥ 1: grant that lane on port 0.
  - Both pending, cap = 2: F's head on port 0, S's head on port 1.
  - Both pending, cap = 1: F's head on port 0 only.
  - Port 1 is never valid without port 0.
  - Each lane pops at most one entry per cycle.
- rr_ptr update:
  - Flips to S whenever both lanes were pending and F was granted.
  - Otherwise unchanged.
  - Result: under contention, lane order alternates 0,1,1,0,… and neither lane starves.
- Outputs: w_val_*/w_data_* are combinational from buffer heads, rr_ptr and size. Unused w_data ports carry all-ones.
- Reset mid-operation: buffered entries are discarded, and w_val drops in the cycle after the reset edge. The producer must treat in-flight items as lost.
- Minimum configuration: with FIFO_DEPTH = 3, cap ≤ 1 while size ≥ 1, so at most one write is issued per cycle.

Optional Feature:
- Macro: FIFO_2W_WR_ARB_STATS_EN
- Defined:
  - Adds outputs stat_cnt_0 and stat_cnt_1, 32 bits each.
  - Each counts entries popped from its lane (i.e. written to the FIFO).
  - Both reset to 0 and wrap modulo 2^32.
  - Also adds stat_stall, 32 bits: counts cycles with at least one lane pending and cap = 0.
- Undefined: these ports and their counters do not exist. Core behaviour is identical.

Test Plan:
- Single lane: FIFO_DEPTH=8, size=0; push 0xA1 on lane 0 in cycle 0 → cycle 1: w_val_0=1, w_data_0=0xA1, w_val_1=0; buffer empty in cycle 2.
- Dual write with rr_ptr=0, size=0: lane 0 holds 0x10, lane 1 holds 0x20 → same cycle: w_data_0=0x10, w_data_1=0x20, both valid; rr_ptr becomes 1.
- Capacity 1: size=6 (DEPTH 8), both lanes pending, rr_ptr=0 → only w_val_0=1 with lane 0 data; rr_ptr becomes 1. Next cycle with size=7 → no writes.
- Backpressure: size held at 7 while 3 pushes are offered on lane 1 → two accepted, in_rdy_1=0 on the third, no w_val. Drop size to 0 → entries emerge in push order, one per cycle.
- Fairness: both lanes streaming, size fixed at 6 → grants alternate lane 0, lane 1, lane 0… over 8 cycles, 4 per lane.
- Reset mid-stream: both buffers full, rst_n=0 for one cycle → next cycle: w_val_0=w_val_1=0, in_rdy_0=in_rdy_1=1; with STATS_EN, all counters read 0.
